// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, field widths and FSM state type for the MDIO responder
package mdio_pkg;

    localparam int FIELD_W = 5;
    localparam int DATA_W  = 16;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] TA_WR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        OP,
        PHYAD,
        REGAD,
        TA,
        RDATA,
        WDATA
    } mdio_state_e;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: two-flop synchronizers for MDC/MDIO plus a registered MDC rising-edge detect
module mdio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [1:0] mdc_q;
    logic [1:0] mdio_q;
    logic       mdc_prev_q;
    logic       rise_q;
    logic       bit_q;

    // synchronize both pins; the MDIO bit is delayed one extra flop so it lines up with the edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_q      <= 2'b00;
            mdio_q     <= 2'b11;
            mdc_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            mdc_q      <= {mdc_q[0], mdc};
            mdio_q     <= {mdio_q[0], mdio_i};
            mdc_prev_q <= mdc_q[1];
            rise_q     <= mdc_q[1] & ~mdc_prev_q;
            bit_q      <= mdio_q[1];
        end
    end

    assign mdc_rise = rise_q;
    assign mdio_s   = bit_q;

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO slave exposing a 32x16 register port to an external station manager
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [FIELD_W-1:0] PHY_ADDR = 5'd1,
    parameter int                 PRE_BITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mdc,
    input  logic               mdio_i,
    output logic               mdio_o,
    output logic               mdio_oe,
    output logic [FIELD_W-1:0] reg_addr,
    output logic               reg_re,
    input  logic [DATA_W-1:0]  reg_rdata,
    output logic               reg_we,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               frame_err
);

    localparam logic [5:0] PRE_N    = 6'(PRE_BITS);
    localparam logic [3:0] FIELD_LS = 4'(FIELD_W - 1);
    localparam logic [3:0] DATA_LS  = 4'(DATA_W - 1);

    logic               mdc_rise;
    logic               bit_s;
    mdio_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [5:0]         pre_q, pre_d;
    logic [DATA_W-1:0]  sh_q, sh_d, sh_in;
    logic               rd_q, rd_d;
    logic               oe_q, oe_d;
    logic               o_q, o_d;
    logic               re_q, re_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [FIELD_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         cap_q, cap_d;

    mdio_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (bit_s)
    );

    assign sh_in = {sh_q[DATA_W-2:0], bit_s};

    // state and datapath registers; reset drops the pad driver immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            oe_q    <= 1'b0;
            o_q     <= 1'b1;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
            o_q     <= o_d;
            re_q    <= re_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
        end
    end

    // frame decoder: every field advances only on a detected MDC rise; read data lands two clk after reg_re
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        sh_d    = cap_q[1] ? reg_rdata : sh_q;
        rd_d    = rd_q;
        oe_d    = oe_q;
        o_d     = o_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = {cap_q[0], re_q};
        if (mdc_rise) begin
            case (state_q)
                IDLE: begin
                    pre_d = bit_s ? ((pre_q < PRE_N) ? pre_q + 6'd1 : pre_q) : 6'd0;
                    state_d = (!bit_s && pre_q >= PRE_N) ? START : IDLE;
                end
                START: begin
                    cnt_d   = '0;
                    state_d = (bit_s == ST[0]) ? OP : IDLE;
                end
                OP: begin
                    sh_d  = sh_in;
                    cnt_d = (cnt_q == 4'd0) ? 4'd1 : 4'd0;
                    if (cnt_q != 4'd0) begin
                        rd_d    = (sh_in[1:0] == OP_RD);
                        state_d = (sh_in[1:0] == OP_RD || sh_in[1:0] == OP_WR) ? PHYAD : IDLE;
                    end
                end
                PHYAD: begin
                    sh_d  = sh_in;
                    cnt_d = (cnt_q == FIELD_LS) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == FIELD_LS)
                        state_d = (sh_in[FIELD_W-1:0] == PHY_ADDR) ? REGAD : IDLE;
                end
                REGAD: begin
                    sh_d  = sh_in;
                    cnt_d = (cnt_q == FIELD_LS) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == FIELD_LS) begin
                        addr_d  = sh_in[FIELD_W-1:0];
                        re_d    = rd_q;
                        state_d = TA;
                    end
                end
                TA: begin
                    if (rd_q) begin
                        cnt_d = (cnt_q == 4'd0) ? 4'd1 : 4'd0;
                        if (cnt_q == 4'd0) begin
                            oe_d = 1'b1;
                            o_d  = 1'b0;
                        end else begin
                            o_d     = sh_q[DATA_W-1];
                            sh_d    = {sh_q[DATA_W-2:0], 1'b0};
                            state_d = RDATA;
                        end
                    end else begin
                        err_d   = (bit_s != TA_WR[cnt_q == 4'd0 ? 1 : 0]);
                        cnt_d   = (cnt_q == 4'd0) ? 4'd1 : 4'd0;
                        state_d = (bit_s != TA_WR[cnt_q == 4'd0 ? 1 : 0]) ? IDLE :
                                  (cnt_q == 4'd0) ? TA : WDATA;
                        cnt_d   = (state_d == TA) ? 4'd1 : 4'd0;
                    end
                end
                RDATA: begin
                    cnt_d = (cnt_q == DATA_LS) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == DATA_LS) begin
                        oe_d    = 1'b0;
                        o_d     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        o_d  = sh_q[DATA_W-1];
                        sh_d = {sh_q[DATA_W-2:0], 1'b0};
                    end
                end
                WDATA: begin
                    sh_d  = sh_in;
                    cnt_d = (cnt_q == DATA_LS) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == DATA_LS) begin
                        wdata_d = sh_in;
                        we_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_q != IDLE) pre_d = 6'd0;
        end
    end

    assign mdio_o    = o_q;
    assign mdio_oe   = oe_q;
    assign reg_addr  = addr_q;
    assign reg_re    = re_q;
    assign reg_we    = we_q;
    assign reg_wdata = wdata_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: station-manager bench with a register-file responder and a behavioural frame model
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_drv = 1'b1;
    logic        mdio_pin;
    logic        mdio_o, mdio_oe, reg_re, reg_we, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_rdata, reg_wdata;

    int passed = 0;
    int total  = 0;

    int re_cnt = 0, we_cnt = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;
    logic [4:0]  re_addr, we_addr;
    logic [15:0] we_data;

    logic [15:0] rf  [32];
    logic [15:0] exp_mem [32];

    logic s_oe, ta1_oe, ta2_pin, ta2_oe, pre_rst_oe, rst_oe, rst_o;

    always #4 clk = ~clk;

    assign mdio_pin = mdio_oe ? mdio_o : mdio_drv;

    mdio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_i    (mdio_pin),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .frame_err (frame_err)
    );

    function automatic logic [15:0] init_val(input int i);
        return (i == 2) ? 16'hA5C3 : 16'(i * 40503 + 4660);
    endfunction

    // strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reg_re) begin re_cnt <= re_cnt + 1; re_addr <= reg_addr; end
        if (reg_we) begin we_cnt <= we_cnt + 1; we_addr <= reg_addr; we_data <= reg_wdata; end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (mdio_oe) oe_cnt <= oe_cnt + 1;
        if (reg_re && reg_we) both_cnt <= both_cnt + 1;
    end

    // emulated register file: data is valid only in the cycle two clk after reg_re
    initial begin
        logic [4:0] a;
        for (int i = 0; i < 32; i++) rf[i] = init_val(i);
        reg_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (reg_we) rf[reg_addr] = reg_wdata;
            if (reg_re) begin
                a = reg_addr;
                @(posedge clk); @(posedge clk); #1;
                reg_rdata = rf[a];
                @(posedge clk); #1;
                reg_rdata = 16'($urandom);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one MDC period of 50 clk (2.5 MHz); the station samples the pin just before the rise
    task automatic do_bit(input logic b, input logic hit, output logic s);
        mdio_drv = b;
        wait_clk(25);
        s    = mdio_pin;
        s_oe = mdio_oe;
        mdc  = 1'b1;
        if (hit) begin
            wait_clk(8);
            pre_rst_oe = mdio_oe;
            rst = 1'b1;
            #1;
            rst_oe = mdio_oe;
            rst_o  = mdio_o;
            wait_clk(2);
            rst = 1'b0;
            wait_clk(15);
        end else begin
            wait_clk(25);
        end
        mdc = 1'b0;
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] wd, input int rst_bit,
                         output logic [15:0] rd);
        logic s;
        logic [13:0] hdr;
        hdr = {2'b01, op, phy, ra};
        repeat (pre) do_bit(1'b1, 1'b0, s);
        for (int i = 13; i >= 0; i--) do_bit(hdr[i], 1'b0, s);
        do_bit(ta[1], 1'b0, s);
        ta1_oe = s_oe;
        do_bit(ta[0], 1'b0, s);
        ta2_pin = s;
        ta2_oe  = s_oe;
        for (int i = 15; i >= 0; i--) begin
            do_bit(wd[i], (i == rst_bit), s);
            rd[i] = s;
        end
        mdio_drv = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        total++; if (mdio_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", mdio_oe); else passed++;
        total++; if (mdio_o !== 1'b1) $display("FAIL reset_o: got %b expected 1", mdio_o); else passed++;
        total++; if (reg_addr !== 5'd0) $display("FAIL reset_addr: got %h expected 0", reg_addr); else passed++;
        total++; if (reg_re !== 1'b0 || reg_we !== 1'b0) $display("FAIL reset_strobes: got re=%b we=%b expected 0 0", reg_re, reg_we); else passed++;
        total++; if (reg_wdata !== 16'h0) $display("FAIL reset_wdata: got %h expected 0000", reg_wdata); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", frame_err); else passed++;
        rst = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_read();
        logic [15:0] rd;
        int re0 = re_cnt, we0 = we_cnt;
        frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, -1, rd);
        total++; if (re_cnt - re0 != 1) $display("FAIL read_re_count: got %0d expected 1", re_cnt - re0); else passed++;
        total++; if (re_addr !== 5'd2) $display("FAIL read_addr: got %h expected 02", re_addr); else passed++;
        total++; if (ta1_oe !== 1'b0) $display("FAIL read_oe_before_ta: got %b expected 0", ta1_oe); else passed++;
        total++; if (ta2_oe !== 1'b1 || ta2_pin !== 1'b0) $display("FAIL read_ta: got oe=%b pin=%b expected 1 0", ta2_oe, ta2_pin); else passed++;
        total++; if (rd !== exp_mem[2]) $display("FAIL read_data: got %h expected %h", rd, exp_mem[2]); else passed++;
        total++; if (mdio_oe !== 1'b0) $display("FAIL read_release: got %b expected 0", mdio_oe); else passed++;
        total++; if (we_cnt != we0) $display("FAIL read_no_we: got %0d expected 0", we_cnt - we0); else passed++;
    endtask

    task automatic test_write();
        logic [15:0] rd;
        int we0 = we_cnt, re0 = re_cnt, oe0 = oe_cnt, err0 = err_cnt;
        frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h1234, -1, rd);
        exp_mem[4] = 16'h1234;
        total++; if (we_cnt - we0 != 1) $display("FAIL write_we_count: got %0d expected 1", we_cnt - we0); else passed++;
        total++; if (we_addr !== 5'd4) $display("FAIL write_addr: got %h expected 04", we_addr); else passed++;
        total++; if (we_data !== 16'h1234) $display("FAIL write_data: got %h expected 1234", we_data); else passed++;
        total++; if (reg_wdata !== 16'h1234) $display("FAIL write_hold: got %h expected 1234", reg_wdata); else passed++;
        total++; if (oe_cnt != oe0) $display("FAIL write_oe: got %0d driven cycles expected 0", oe_cnt - oe0); else passed++;
        total++; if (re_cnt != re0 || err_cnt != err0) $display("FAIL write_side: got re=%0d err=%0d expected 0 0", re_cnt - re0, err_cnt - err0); else passed++;
    endtask

    task automatic test_mismatch();
        logic [15:0] rd;
        int re0 = re_cnt, oe0 = oe_cnt;
        frame(32, 2'b10, 5'd3, 5'd4, 2'b11, 16'hFFFF, -1, rd);
        total++; if (re_cnt != re0) $display("FAIL mismatch_re: got %0d expected 0", re_cnt - re0); else passed++;
        total++; if (oe_cnt != oe0) $display("FAIL mismatch_oe: got %0d driven cycles expected 0", oe_cnt - oe0); else passed++;
        frame(32, 2'b10, 5'd1, 5'd4, 2'b11, 16'hFFFF, -1, rd);
        total++; if (rd !== exp_mem[4]) $display("FAIL mismatch_followup: got %h expected %h", rd, exp_mem[4]); else passed++;
    endtask

    task automatic test_preamble();
        logic [15:0] rd;
        int re0 = re_cnt, oe0 = oe_cnt;
        frame(31, 2'b10, 5'd1, 5'd7, 2'b11, 16'hFFFF, -1, rd);
        total++; if (re_cnt != re0 || oe_cnt != oe0) $display("FAIL short_preamble: got re=%0d oe=%0d expected 0 0", re_cnt - re0, oe_cnt - oe0); else passed++;
        frame(32, 2'b10, 5'd1, 5'd7, 2'b11, 16'hFFFF, -1, rd);
        total++; if (rd !== exp_mem[7]) $display("FAIL full_preamble: got %h expected %h", rd, exp_mem[7]); else passed++;
    endtask

    task automatic test_errors();
        logic [15:0] rd;
        int err0 = err_cnt, we0 = we_cnt, re0 = re_cnt;
        frame(32, 2'b01, 5'd1, 5'd5, 2'b11, 16'hBEEF, -1, rd);
        total++; if (err_cnt - err0 != 1) $display("FAIL bad_ta_err: got %0d expected 1", err_cnt - err0); else passed++;
        total++; if (we_cnt != we0) $display("FAIL bad_ta_we: got %0d expected 0", we_cnt - we0); else passed++;
        err0 = err_cnt;
        frame(32, 2'b11, 5'd1, 5'd5, 2'b10, 16'hBEEF, -1, rd);
        total++; if (err_cnt != err0 || we_cnt != we0 || re_cnt != re0) $display("FAIL bad_op: got err=%0d we=%0d re=%0d expected 0 0 0", err_cnt - err0, we_cnt - we0, re_cnt - re0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        frame(32, 2'b10, 5'd1, 5'd9, 2'b11, 16'hFFFF, 7, rd);
        total++; if (pre_rst_oe !== 1'b1) $display("FAIL midreset_driving: got %b expected 1", pre_rst_oe); else passed++;
        total++; if (rst_oe !== 1'b0 || rst_o !== 1'b1) $display("FAIL midreset_pad: got oe=%b o=%b expected 0 1", rst_oe, rst_o); else passed++;
        frame(32, 2'b10, 5'd1, 5'd9, 2'b11, 16'hFFFF, -1, rd);
        total++; if (rd !== exp_mem[9]) $display("FAIL midreset_recover: got %h expected %h", rd, exp_mem[9]); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] rd, wd;
        logic [4:0] phy, ra;
        logic is_rd, acc;
        int pre, re0, we0;
        for (int n = 0; n < 6; n++) begin
            is_rd = 1'($urandom_range(0, 1));
            phy   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd1;
            pre   = ($urandom_range(0, 3) == 0) ? 31 : 32;
            ra    = 5'($urandom);
            wd    = 16'($urandom);
            acc   = (pre >= 32) && (phy == 5'd1);
            re0 = re_cnt; we0 = we_cnt;
            if (is_rd) begin
                frame(pre, 2'b10, phy, ra, 2'b11, 16'hFFFF, -1, rd);
                total++; if (rd !== (acc ? exp_mem[ra] : 16'hFFFF)) $display("FAIL rand_read %0d: got %h expected %h", n, rd, acc ? exp_mem[ra] : 16'hFFFF); else passed++;
                total++; if (re_cnt - re0 != int'(acc)) $display("FAIL rand_re %0d: got %0d expected %0d", n, re_cnt - re0, acc); else passed++;
            end else begin
                frame(pre, 2'b01, phy, ra, 2'b10, wd, -1, rd);
                total++; if (we_cnt - we0 != int'(acc)) $display("FAIL rand_we %0d: got %0d expected %0d", n, we_cnt - we0, acc); else passed++;
                if (acc) begin
                    exp_mem[ra] = wd;
                    total++; if (we_addr !== ra || we_data !== wd) $display("FAIL rand_wr %0d: got %h/%h expected %h/%h", n, we_addr, we_data, ra, wd); else passed++;
                end
            end
        end
        frame(32, 2'b10, 5'd1, ra, 2'b11, 16'hFFFF, -1, rd);
        total++; if (rd !== exp_mem[ra]) $display("FAIL rand_readback: got %h expected %h", rd, exp_mem[ra]); else passed++;
        total++; if (both_cnt != 0) $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
        test_reset();
        test_read();
        test_write();
        test_mismatch();
        test_preamble();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
